// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS32 run controller and anything that drives it.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClrRf,
        StLoad,
        StRun,
        StDone,
        StErr
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OVF     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    // Opcode field of the HLT instruction, for program generators.
    localparam logic [5:0] OP_HLT = 6'h3f;

endpackage

// File: rtl/ctrl_counter.sv
// Clearable, enabled up-counter with a compare against a terminal value.
module ctrl_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_at_term
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_at_term = (r_count == i_term);

endmodule

// File: rtl/mips_run_ctrl.sv
// Sequences one core execution: register-file init, program load over a
// valid/ready stream, then a supervised run ending in HALT, timeout or abort.
module mips_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned AW      = 10,
    parameter int unsigned NREG    = 32,
    parameter int unsigned CW      = 32,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic          i_clk1,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_rf_init_idx,
    input  logic          i_prog_valid,
    output logic          o_prog_ready,
    input  logic [31:0]   i_prog_data,
    input  logic          i_prog_last,
    output logic          o_imem_we,
    output logic [AW-1:0] o_imem_addr,
    output logic [31:0]   o_imem_wdata,
    output logic          o_rf_we,
    output logic [4:0]    o_rf_addr,
    output logic [31:0]   o_rf_wdata,
    output logic          o_core_clr,
    output logic          o_core_run,
    input  logic          i_core_halted,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [1:0]    o_err_code,
    output logic [CW-1:0] o_cycles,
    output logic [AW:0]   o_prog_len
);

    localparam int unsigned   PW        = AW + 1;
    localparam logic [4:0]    RF_LAST   = 5'(NREG - 1);
    localparam logic [PW-1:0] IMEM_LAST = PW'((2 ** AW) - 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(TIMEOUT - 1);

    state_e        r_state;
    state_e        w_state_d;
    logic [1:0]    r_err_code;
    logic [1:0]    w_err_code_d;

    logic          w_start_ok;
    logic          w_accept;
    logic [4:0]    w_rf_idx;
    logic          w_rf_last;
    logic [PW-1:0] w_prog_len;
    logic          w_imem_last;
    logic [CW-1:0] w_cycles;
    logic          w_cyc_last;

    assign w_start_ok = i_start &
                        ((r_state == StIdle) | (r_state == StDone) | (r_state == StErr));
    assign w_accept   = (r_state == StLoad) & i_prog_valid;

    ctrl_counter #(
        .W (5)
    ) u_rf_cnt (
        .i_clk     (i_clk1),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_start_ok),
        .i_en      (r_state == StClrRf),
        .i_term    (RF_LAST),
        .o_count   (w_rf_idx),
        .o_at_term (w_rf_last)
    );

    ctrl_counter #(
        .W (PW)
    ) u_len_cnt (
        .i_clk     (i_clk1),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_start_ok),
        .i_en      (w_accept),
        .i_term    (IMEM_LAST),
        .o_count   (w_prog_len),
        .o_at_term (w_imem_last)
    );

    // Counts every edge spent in RUN, so the exiting edge is included.
    ctrl_counter #(
        .W (CW)
    ) u_cyc_cnt (
        .i_clk     (i_clk1),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_start_ok),
        .i_en      (r_state == StRun),
        .i_term    (CYC_LAST),
        .o_count   (w_cycles),
        .o_at_term (w_cyc_last)
    );

    always_ff @(posedge i_clk1 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_d;
            r_err_code <= w_err_code_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_err_code_d = r_err_code;
        unique case (r_state)
            StIdle, StDone, StErr: begin
                if (i_start) begin
                    w_state_d    = StClrRf;
                    w_err_code_d = ERR_NONE;
                end
            end
            StClrRf: begin
                if (i_abort) begin
                    w_state_d    = StErr;
                    w_err_code_d = ERR_ABORT;
                end else if (w_rf_last) begin
                    w_state_d = StLoad;
                end
            end
            StLoad: begin
                // A beat accepted alongside abort is still written by the counter path.
                if (i_abort) begin
                    w_state_d    = StErr;
                    w_err_code_d = ERR_ABORT;
                end else if (w_accept) begin
                    if (i_prog_last) begin
                        w_state_d = StRun;
                    end else if (w_imem_last) begin
                        w_state_d    = StErr;
                        w_err_code_d = ERR_OVF;
                    end
                end
            end
            StRun: begin
                if (i_abort) begin
                    w_state_d    = StErr;
                    w_err_code_d = ERR_ABORT;
                end else if (i_core_halted) begin
                    w_state_d = StDone;
                end else if (w_cyc_last) begin
                    w_state_d    = StErr;
                    w_err_code_d = ERR_TIMEOUT;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        o_prog_ready = 1'b0;
        o_imem_we    = 1'b0;
        o_imem_wdata = '0;
        o_rf_we      = 1'b0;
        o_rf_wdata   = '0;
        o_core_clr   = 1'b0;
        o_core_run   = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_imem_addr  = w_prog_len[AW-1:0];
        o_rf_addr    = w_rf_idx;
        o_err_code   = r_err_code;
        o_cycles     = w_cycles;
        o_prog_len   = w_prog_len;
        unique case (r_state)
            StClrRf: begin
                o_core_clr = 1'b1;
                o_rf_we    = 1'b1;
                o_rf_wdata = i_rf_init_idx ? {27'd0, w_rf_idx} : 32'd0;
                o_busy     = 1'b1;
            end
            StLoad: begin
                o_core_clr   = 1'b1;
                o_prog_ready = 1'b1;
                o_imem_we    = i_prog_valid;
                o_imem_wdata = i_prog_valid ? i_prog_data : 32'd0;
                o_busy       = 1'b1;
            end
            StRun: begin
                o_core_run = 1'b1;
                o_busy     = 1'b1;
            end
            StDone: begin
                o_done = 1'b1;
            end
            StErr: begin
                o_err = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Randomised scoreboard bench for mips_run_ctrl with a tiny behavioural core
// (ADD/ADDI/HLT) standing in for the MIPS32 pipeline.
module tb_mips_run_ctrl;
    import mips_ctrl_pkg::*;

    localparam int unsigned AW      = 4;
    localparam int unsigned NREG    = 32;
    localparam int unsigned CW      = 32;
    localparam int unsigned TIMEOUT = 50;
    localparam int          CAP     = 1 << AW;
    localparam int          NEVER   = 1 << 30;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          rf_init_idx = 1'b0;
    logic          prog_valid = 1'b0;
    logic          prog_last = 1'b0;
    logic [31:0]   prog_data = 32'd0;
    logic          prog_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          rf_we;
    logic [4:0]    rf_addr;
    logic [31:0]   rf_wdata;
    logic          core_clr;
    logic          core_run;
    logic          core_halted;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [CW-1:0] cycles;
    logic [AW:0]   prog_len;

    logic          force_halt = 1'b0;
    logic          core_halted_m = 1'b0;
    assign core_halted = core_halted_m | force_halt;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .AW      (AW),
        .NREG    (NREG),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk1        (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_abort       (abort),
        .i_rf_init_idx (rf_init_idx),
        .i_prog_valid  (prog_valid),
        .o_prog_ready  (prog_ready),
        .i_prog_data   (prog_data),
        .i_prog_last   (prog_last),
        .o_imem_we     (imem_we),
        .o_imem_addr   (imem_addr),
        .o_imem_wdata  (imem_wdata),
        .o_rf_we       (rf_we),
        .o_rf_addr     (rf_addr),
        .o_rf_wdata    (rf_wdata),
        .o_core_clr    (core_clr),
        .o_core_run    (core_run),
        .i_core_halted (core_halted),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .o_err_code    (err_code),
        .o_cycles      (cycles),
        .o_prog_len    (prog_len)
    );

    // Behavioural core: one instruction per enabled cycle, fetched from what was loaded.
    logic [31:0] imem_m [CAP];
    logic [31:0] regs_m [NREG];
    logic [31:0] ins_m;
    int          pc_m = 0;
    int          wcnt_m = 0;

    always @(posedge clk) begin
        if (imem_we) begin
            imem_m[imem_addr] <= imem_wdata;
            wcnt_m <= wcnt_m + 1;
        end
        if (rf_we) begin
            regs_m[rf_addr] <= rf_wdata;
            wcnt_m <= 0;
        end
        if (core_clr) begin
            pc_m <= 0;
            core_halted_m <= 1'b0;
        end else if (core_run && !core_halted_m) begin
            if (pc_m < wcnt_m) begin
                ins_m = imem_m[pc_m];
                case (ins_m[31:26])
                    6'h0a: if (ins_m[20:16] != 5'd0)
                        regs_m[ins_m[20:16]] <= regs_m[ins_m[25:21]] +
                                                {{16{ins_m[15]}}, ins_m[15:0]};
                    6'h00: if (ins_m[15:11] != 5'd0)
                        regs_m[ins_m[15:11]] <= regs_m[ins_m[25:21]] + regs_m[ins_m[20:16]];
                    OP_HLT: core_halted_m <= 1'b1;
                    default: ;
                endcase
            end
            pc_m <= (pc_m + 1) % CAP;
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } iw_t;
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rw_t;
    typedef struct packed {
        logic          done;
        logic          err;
        logic [1:0]    code;
        logic [CW-1:0] cycles;
        logic [AW:0]   plen;
    } res_t;

    iw_t         q_iw[$];
    rw_t         q_rw[$];
    res_t        q_res[$];
    logic [31:0] prog_q[$];
    int          n_vec = 0;
    int          n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_ctrl"}, 64'({prog_ready, imem_we, imem_addr, rf_we, rf_addr, core_clr,
                                 core_run, busy, done, err, err_code, prog_len}), 64'd0);
        chk({tag, "_data"}, {imem_wdata, rf_wdata}, 64'd0);
        chk({tag, "_cycles"}, 64'(cycles), 64'd0);
    endtask

    // Outcome from the rules: earliest of abort / halt / watchdog, abort winning ties,
    // halt beating the watchdog on the same cycle.
    function automatic res_t model(input int n, input bit last_final, input int abort_load,
                                   input int abort_run, input int fh, input int hlt);
        res_t r;
        int   t_ab;
        int   t_h;
        int   t;
        r = '0;
        if (abort_load >= 0) begin
            r.err  = 1'b1;
            r.code = ERR_ABORT;
            r.plen = (AW + 1)'(abort_load);
            return r;
        end
        if (!last_final) begin
            r.err  = 1'b1;
            r.code = ERR_OVF;
            r.plen = (AW + 1)'(CAP);
            return r;
        end
        r.plen = (AW + 1)'(n);
        t_ab = (abort_run >= 0) ? abort_run + 1 : NEVER;
        t_h  = NEVER;
        if (hlt >= 0) t_h = hlt + 2;
        if (fh >= 0 && fh + 1 < t_h) t_h = fh + 1;
        t = TIMEOUT;
        if (t_h < t) t = t_h;
        if (t_ab < t) t = t_ab;
        r.cycles = CW'(t);
        if (t_ab == t) begin
            r.err  = 1'b1;
            r.code = ERR_ABORT;
        end else if (t_h == t) begin
            r.done = 1'b1;
        end else begin
            r.err  = 1'b1;
            r.code = ERR_TIMEOUT;
        end
        return r;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a write or a completion.
    iw_t  m_iw;
    rw_t  m_rw;
    res_t m_res;
    logic fin_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            fin_prev = 1'b0;
        end else begin
            if (imem_we) begin
                n_vec++;
                if (q_iw.size() == 0) begin
                    n_miss++;
                    $display("FAIL imem_unexpected: got write addr %0d, expected none", imem_addr);
                end else begin
                    m_iw = q_iw.pop_front();
                    chk("imem_addr", 64'(imem_addr), 64'(m_iw.addr));
                    chk("imem_data", 64'(imem_wdata), 64'(m_iw.data));
                end
            end
            if (rf_we) begin
                n_vec++;
                if (q_rw.size() == 0) begin
                    n_miss++;
                    $display("FAIL rf_unexpected: got write addr %0d, expected none", rf_addr);
                end else begin
                    m_rw = q_rw.pop_front();
                    chk("rf_addr", 64'(rf_addr), 64'(m_rw.addr));
                    chk("rf_data", 64'(rf_wdata), 64'(m_rw.data));
                end
            end
            if ((done | err) && !fin_prev) begin
                n_vec++;
                if (q_res.size() == 0) begin
                    n_miss++;
                    $display("FAIL result_unexpected: got done=%0b err=%0b, expected none",
                             done, err);
                end else begin
                    m_res = q_res.pop_front();
                    chk("done", 64'(done), 64'(m_res.done));
                    chk("err", 64'(err), 64'(m_res.err));
                    chk("err_code", 64'(err_code), 64'(m_res.code));
                    chk("cycles", 64'(cycles), 64'(m_res.cycles));
                    chk("prog_len", 64'(prog_len), 64'(m_res.plen));
                    chk("run_dropped", 64'(core_run), 64'd0);
                end
            end
            fin_prev = done | err;
        end
    end

    task automatic run_seq(input bit last_final, input bit gaps, input int abort_load,
                           input int abort_run, input int fh, input bit init_idx,
                           input int rst_at);
        int          n;
        int          i;
        int          hlt;
        int          guard;
        int          dmax;
        bit          ph;
        logic [31:0] w;
        rw_t         e_rw;
        iw_t         e_iw;
        n   = prog_q.size();
        hlt = -1;
        for (int k = 0; k < n; k++) begin
            w = prog_q[k];
            if (hlt < 0 && w[31:26] == OP_HLT) hlt = k;
        end
        rf_init_idx = init_idx;
        for (int k = 0; k < NREG; k++) begin
            e_rw.addr = 5'(k);
            e_rw.data = init_idx ? 32'(k) : 32'd0;
            q_rw.push_back(e_rw);
        end
        if (rst_at < 0) q_res.push_back(model(n, last_final, abort_load, abort_run, fh, hlt));

        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!prog_ready && guard < NREG + 5) begin
            tick();
            guard++;
        end
        chk("load_entered", 64'(prog_ready), 64'd1);

        i  = 0;
        ph = 1'b0;
        while (i < n && prog_ready) begin
            if (abort_load == i) begin
                start      = 1'b0;
                prog_valid = 1'b0;
                abort      = 1'b1;
                tick();
                abort = 1'b0;
                break;
            end
            start = ($urandom_range(0, 3) == 0);
            ph    = ~ph;
            if (gaps && !ph) begin
                prog_valid = 1'b0;
                tick();
            end else begin
                prog_valid = 1'b1;
                prog_data  = prog_q[i];
                prog_last  = last_final && (i == n - 1);
                e_iw.addr  = AW'(i);
                e_iw.data  = prog_q[i];
                q_iw.push_back(e_iw);
                tick();
                i++;
            end
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        start      = 1'b0;
        if (last_final && abort_load < 0 && i == n)
            chk("run_follows_last", 64'(core_run), 64'd1);

        dmax = abort_run;
        if (fh > dmax) dmax = fh;
        if (rst_at > dmax) dmax = rst_at;
        for (int d = 0; d <= dmax; d++) begin
            if (d == rst_at) begin
                #2 rst_n = 1'b0;
                #1 zero_check("async_reset");
                q_iw.delete();
                q_rw.delete();
                q_res.delete();
                #2 rst_n = 1'b1;
                tick();
                return;
            end
            abort      = (d == abort_run);
            force_halt = (d == fh);
            tick();
        end
        abort      = 1'b0;
        force_halt = 1'b0;

        guard = 0;
        while (!(done || err) && guard < TIMEOUT + 10) begin
            tick();
            guard++;
        end
        chk("finished_in_time", 64'(done || err), 64'd1);
        tick();
        tick();
        chk("imem_queue_drained", 64'(q_iw.size()), 64'd0);
        chk("rf_queue_drained", 64'(q_rw.size()), 64'd0);
        chk("result_queue_drained", 64'(q_res.size()), 64'd0);
        q_iw.delete();
        q_rw.delete();
        q_res.delete();
    endtask

    logic [31:0] norm_prog [9] = '{
        32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
        32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000
    };
    logic [31:0] addi_prog [4] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h28040005};

    task automatic load_norm();
        prog_q.delete();
        for (int k = 0; k < 9; k++) prog_q.push_back(norm_prog[k]);
    endtask

    task automatic load_addi();
        prog_q.delete();
        for (int k = 0; k < 4; k++) prog_q.push_back(addi_prog[k]);
    endtask

    task automatic load_random(input int n, input bit with_hlt);
        prog_q.delete();
        for (int k = 0; k < n; k++)
            prog_q.push_back({6'h0a, 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)),
                              16'($urandom)});
        if (with_hlt) prog_q[n - 1] = {OP_HLT, 26'd0};
    endtask

    initial begin
        #1 zero_check("reset");
        #10 rst_n = 1'b1;
        tick();

        load_norm();
        run_seq(1'b1, 1'b0, -1, -1, -1, 1'b1, -1);
        chk("reg_r1", 64'(regs_m[1]), 64'd10);
        chk("reg_r2", 64'(regs_m[2]), 64'd20);
        chk("reg_r3", 64'(regs_m[3]), 64'd25);
        chk("reg_r4", 64'(regs_m[4]), 64'd30);
        chk("reg_r5", 64'(regs_m[5]), 64'd55);

        load_norm();
        run_seq(1'b1, 1'b1, -1, -1, -1, 1'b0, -1);

        load_addi();
        run_seq(1'b1, 1'b0, -1, -1, -1, 1'b1, -1);

        load_random(CAP + 1, 1'b0);
        run_seq(1'b0, 1'b0, -1, -1, -1, 1'b1, -1);

        load_norm();
        run_seq(1'b1, 1'b0, 3, -1, -1, 1'b1, -1);

        load_addi();
        run_seq(1'b1, 1'b0, -1, 5, 5, 1'b1, -1);

        load_addi();
        run_seq(1'b1, 1'b0, -1, -1, TIMEOUT - 1, 1'b0, -1);

        load_addi();
        run_seq(1'b1, 1'b0, -1, -1, -1, 1'b1, 7);
        load_norm();
        run_seq(1'b1, 1'b0, -1, -1, -1, 1'b1, -1);

        for (int r = 0; r < 12; r++) begin
            load_random($urandom_range(1, CAP), 1'($urandom_range(0, 1)));
            run_seq(1'b1, 1'($urandom_range(0, 1)), -1,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(0, 60) : -1,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(0, 60) : -1,
                    1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Run controller that sequences one execution of the pipelined MIPS32 core. It initialises the register file and loads a program into instruction memory over a valid/ready stream. It then holds the core cleared, releases it, and watches for HALT. It reports completion, elapsed run cycles, or an error (overflow, timeout, abort), so benches and top-level integration no longer poke core state hierarchically.

Parameters:
AW, 10, instruction-memory word-address width (capacity 2^AW words)
NREG, 32, register-file entries to initialise
CW, 32, run-cycle counter width
TIMEOUT, 1000, max RUN cycles before watchdog error (1 .. 2^CW-1)

Ports:
clk1  in  1  single controller clock, shared with the core
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a load+run sequence
abort  in  1  force termination of the current sequence
rf_init_idx  in  1  1: REG[k]=k during init; 0: REG[k]=0
prog_valid  in  1  program word available
prog_ready  out  1  controller accepts program word
prog_data  in  32  instruction word
prog_last  in  1  marks final program word
imem_we  out  1  instruction-memory write strobe
imem_addr  out  AW  instruction-memory write address
imem_wdata  out  32  instruction-memory write data
rf_we  out  1  register-file init write strobe
rf_addr  out  5  register-file init address
rf_wdata  out  32  register-file init data
core_clr  out  1  core clears PC, HALTED, TAKEN_BRANCH and pipeline latches
core_run  out  1  core clock-enable; core advances only when high
core_halted  in  1  core HALTED flag
busy  out  1  state is CLR_RF, LOAD or RUN
done  out  1  sticky; run ended by HALT
err  out  1  sticky; run ended by error
err_code  out  2  0 none, 1 imem overflow, 2 timeout, 3 abort
cycles  out  CW  cycles spent in RUN
prog_len  out  AW+1  words written to imem

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0, including cycles, prog_len and err_code.
- States: IDLE, CLR_RF, LOAD, RUN, DONE, ERR. All registered; outputs decode from registered state and counters.
- IDLE/DONE/ERR with start=1: go to CLR_RF next edge; clear done, err, err_code, cycles, prog_len, rf index. start is ignored in CLR_RF/LOAD/RUN.
- CLR_RF: core_clr=1, rf_we=1, rf_addr=k for k=0..NREG-1 on consecutive cycles; rf_wdata = rf_init_idx ? k : 0. Exactly NREG writes, then LOAD.
- LOAD: core_clr=1, prog_ready=1. A beat is accepted when prog_valid&prog_ready. The accepting cycle drives imem_we=1, imem_addr=prog_len[AW-1:0], imem_wdata=prog_data, and prog_len increments. Idle valid cycles stall indefinitely; no timeout in LOAD.
- LOAD exit: accepted beat with prog_last=1 goes to RUN next edge. An accepted beat at address 2^AW-1 with prog_last=0 is still written, then goes to ERR with code 1. An accepted beat at 2^AW-1 with prog_last=1 goes to RUN normally. Zero-length programs are impossible; the first beat is always written.
- RUN: core_clr=0, core_run=1, prog_ready=0. cycles increments on every edge taken while in RUN, including the exiting edge.
- RUN exits, evaluated each cycle with priority abort > core_halted > timeout:
  - abort: ERR, code 3.
  - core_halted=1: DONE.
  - cycles==TIMEOUT-1: ERR, code 2, so cycles finishes at TIMEOUT.
- core_run drops the cycle after exit. core_halted is ignored outside RUN; the core must clear HALTED while core_clr=1.
- abort in CLR_RF or LOAD: ERR, code 3 next edge; a beat accepted in that same cycle is still written. abort in IDLE/DONE/ERR: no effect.
- DONE/ERR: done or err held at 1; cycles, prog_len and err_code frozen until the next start or reset.
- Reset mid-sequence: immediate IDLE; imem/rf contents are undefined to the caller.

Decomposition:
- Package mips_ctrl_pkg: state enumeration; err_code constants (ERR_NONE, ERR_OVF, ERR_TIMEOUT, ERR_ABORT); HLT opcode constant 6'h3f for benches.
- Sub-module ctrl_counter: parameterised width, clear/enable up-counter with terminal-value compare. Instantiated three times: rf index, imem address/prog_len, run cycles.

Test Plan:
- Normal run: rf_init_idx=1, stream 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 (last on 9th) -> NREG rf writes with data=k, 9 imem writes at addr 0..8, prog_len=9. done=1, err=0, 0<cycles<TIMEOUT; REG R1=10, R2=20, R3=25, R4=30, R5=55.
- Backpressure: same stream with prog_valid low on alternate cycles -> identical imem contents and prog_len=9; core_run first high exactly one cycle after the last-beat accept.
- Timeout: TIMEOUT=50, program of 4 ADDIs without HLT -> err=1, err_code=2, cycles=50; core_run low from the next cycle.
- Overflow: AW=3, 9 beats with no prog_last -> 8 writes at addr 0..7, err_code=1, prog_len=8, core_run never asserted.
- Abort/priority: abort in LOAD -> ERR, code 3. In RUN, abort and core_halted in the same cycle -> code 3, done=0. core_halted on the TIMEOUT-1 cycle -> done=1, cycles=TIMEOUT.
- Reset mid-RUN: rst_n low asynchronously -> all outputs 0 before the next clk1 edge. A subsequent start re-runs the full sequence with fresh counters.
